// File: rtl/mem_access_requester.sv
// MEM-stage initiator for the data memory: address check, req/ack handshake
// toward a multi-cycle responder, pipeline freeze and ack timeout.
module mem_access_requester #(
  parameter int unsigned BaseAddr      = 1024,
  parameter int unsigned WordCount     = 64,
  parameter int unsigned AdrWidth      = 6,
  parameter int unsigned TimeoutCycles = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                MEM_R_ENIn,
  input  logic                MEM_W_ENIn,
  input  logic [31:0]         ALU_ResIn,
  input  logic [31:0]         Value_RmIn,
  output logic                freeze,
  output logic [31:0]         resultOut,
  output logic                result_valid,
  output logic                mem_req,
  output logic                mem_we,
  output logic [AdrWidth-1:0] mem_adr,
  output logic [31:0]         mem_wdata,
  input  logic                mem_ack,
  input  logic [31:0]         mem_rdata,
  output logic                err_range,
  output logic                err_timeout
);

  localparam logic [31:0] BaseAddrW   = 32'(BaseAddr);
  localparam logic [31:0] SpanBytes   = 32'(4 * WordCount);
  localparam logic [7:0]  TimeoutLast = 8'(TimeoutCycles - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, stateNext;

  logic                op;
  logic                addrLegal;
  logic [31:0]         byteOffset;
  logic [7:0]          timer, timerNext;
  logic                reqNext, weNext, validNext, errRangeNext, errTimeoutNext;
  logic [AdrWidth-1:0] adrNext;
  logic [31:0]         wdataNext, resultNext;

  assign op         = MEM_R_ENIn | MEM_W_ENIn;
  assign byteOffset = ALU_ResIn - BaseAddrW;
  // Unsigned wrap makes addresses below BaseAddr compare as huge offsets,
  // so a single compare covers both range bounds.
  assign addrLegal  = (byteOffset < SpanBytes) && (ALU_ResIn[1:0] == 2'b00);
  assign freeze     = op && (state != DONE) && !rst;

  always_comb begin
    stateNext      = state;
    reqNext        = mem_req;
    weNext         = mem_we;
    adrNext        = mem_adr;
    wdataNext      = mem_wdata;
    resultNext     = resultOut;
    timerNext      = timer;
    validNext      = 1'b0;
    errRangeNext   = 1'b0;
    errTimeoutNext = 1'b0;
    case (state)
      IDLE: begin
        if (op) begin
          if (addrLegal) begin
            reqNext   = 1'b1;
            weNext    = MEM_W_ENIn;
            adrNext   = byteOffset[AdrWidth+1:2];
            wdataNext = Value_RmIn;
            timerNext = '0;
            stateNext = BUSY;
          end else begin
            errRangeNext = 1'b1;
            if (!MEM_W_ENIn) begin
              resultNext = '0;
              validNext  = 1'b1;
            end
            stateNext = DONE;
          end
        end
      end
      BUSY: begin
        if (mem_ack) begin
          reqNext = 1'b0;
          if (!mem_we) begin
            resultNext = mem_rdata;
            validNext  = 1'b1;
          end
          stateNext = DONE;
        end else if (timer == TimeoutLast) begin
          reqNext        = 1'b0;
          errTimeoutNext = 1'b1;
          if (!mem_we) begin
            resultNext = '0;
            validNext  = 1'b1;
          end
          stateNext = DONE;
        end else begin
          timerNext = timer + 8'd1;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_adr      <= '0;
      mem_wdata    <= '0;
      resultOut    <= '0;
      result_valid <= 1'b0;
      err_range    <= 1'b0;
      err_timeout  <= 1'b0;
      timer        <= '0;
    end else begin
      state        <= stateNext;
      mem_req      <= reqNext;
      mem_we       <= weNext;
      mem_adr      <= adrNext;
      mem_wdata    <= wdataNext;
      resultOut    <= resultNext;
      result_valid <= validNext;
      err_range    <= errRangeNext;
      err_timeout  <= errTimeoutNext;
      timer        <= timerNext;
    end
  end

endmodule

// File: tb/tb_mem_access_requester.sv
// Directed bench for mem_access_requester: inputs change 1 ns after the rising
// edge, outputs are checked 1 ns later.
module tb_mem_access_requester;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_R_ENIn, MEM_W_ENIn;
  logic [31:0] ALU_ResIn, Value_RmIn;
  logic        freeze;
  logic [31:0] resultOut;
  logic        result_valid;
  logic        mem_req, mem_we;
  logic [5:0]  mem_adr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        err_range, err_timeout;

  int checks = 0;
  int errors = 0;

  mem_access_requester #(
    .BaseAddr(1024), .WordCount(64), .AdrWidth(6), .TimeoutCycles(15)
  ) dut (
    .clk(clk), .rst(rst), .MEM_R_ENIn(MEM_R_ENIn), .MEM_W_ENIn(MEM_W_ENIn),
    .ALU_ResIn(ALU_ResIn), .Value_RmIn(Value_RmIn), .freeze(freeze),
    .resultOut(resultOut), .result_valid(result_valid), .mem_req(mem_req),
    .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err_range(err_range),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; MEM_R_ENIn = 1'b1;
    nextCycle(); nextCycle(); #1;
    checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL reset_freeze: got %0b exp 0", freeze); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b exp 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b exp 0", mem_we); end
    checks++; if (mem_adr !== 6'd0) begin errors++; $display("FAIL reset_adr: got %0d exp 0", mem_adr); end
    checks++; if (mem_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %h exp 0", mem_wdata); end
    checks++; if (resultOut !== 32'd0) begin errors++; $display("FAIL reset_result: got %h exp 0", resultOut); end
    checks++; if ({result_valid, err_range, err_timeout} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b exp 000", {result_valid, err_range, err_timeout}); end
    rst = 1'b0; MEM_R_ENIn = 1'b0; mem_ack = 1'b1;
    nextCycle(); nextCycle(); mem_ack = 1'b0; #1;
    checks++; if ({mem_req, result_valid} !== 2'b00) begin errors++; $display("FAIL idle_ack_ignored: got %b exp 00", {mem_req, result_valid}); end
  endtask

  task automatic test_store();
    nextCycle(); MEM_W_ENIn = 1'b1; ALU_ResIn = 32'd1032; Value_RmIn = 32'hDEADBEEF; #1;
    checks++; if ({freeze, mem_req} !== 2'b10) begin errors++; $display("FAIL store_idle: got freeze,req=%b exp 10", {freeze, mem_req}); end
    nextCycle(); #1;
    checks++; if ({freeze, mem_req, mem_we} !== 3'b111) begin errors++; $display("FAIL store_busy1: got freeze,req,we=%b exp 111", {freeze, mem_req, mem_we}); end
    checks++; if (mem_adr !== 6'd2) begin errors++; $display("FAIL store_adr: got %0d exp 2", mem_adr); end
    checks++; if (mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL store_wdata: got %h exp deadbeef", mem_wdata); end
    nextCycle(); mem_ack = 1'b1; #1;
    checks++; if ({freeze, mem_req} !== 2'b11) begin errors++; $display("FAIL store_busy2: got freeze,req=%b exp 11", {freeze, mem_req}); end
    nextCycle(); mem_ack = 1'b0; #1;
    checks++; if ({freeze, mem_req, result_valid} !== 3'b000) begin errors++; $display("FAIL store_done: got freeze,req,valid=%b exp 000", {freeze, mem_req, result_valid}); end
    checks++; if (resultOut !== 32'd0) begin errors++; $display("FAIL store_result: got %h exp 0", resultOut); end
    nextCycle(); MEM_W_ENIn = 1'b0;
  endtask

  task automatic test_load();
    nextCycle(); MEM_R_ENIn = 1'b1; ALU_ResIn = 32'd1024; #1;
    checks++; if ({freeze, mem_req} !== 2'b10) begin errors++; $display("FAIL load_idle: got freeze,req=%b exp 10", {freeze, mem_req}); end
    nextCycle(); mem_ack = 1'b1; mem_rdata = 32'h12345678; #1;
    checks++; if ({freeze, mem_req, mem_we} !== 3'b110) begin errors++; $display("FAIL load_busy: got freeze,req,we=%b exp 110", {freeze, mem_req, mem_we}); end
    checks++; if (mem_adr !== 6'd0) begin errors++; $display("FAIL load_adr: got %0d exp 0", mem_adr); end
    nextCycle(); mem_ack = 1'b0; #1;
    checks++; if ({freeze, mem_req, result_valid} !== 3'b001) begin errors++; $display("FAIL load_done: got freeze,req,valid=%b exp 001", {freeze, mem_req, result_valid}); end
    checks++; if (resultOut !== 32'h12345678) begin errors++; $display("FAIL load_result: got %h exp 12345678", resultOut); end
    nextCycle(); MEM_R_ENIn = 1'b0; #1;
    checks++; if ({result_valid, resultOut} !== {1'b0, 32'h12345678}) begin errors++; $display("FAIL load_hold: got valid=%b result=%h exp 0/12345678", result_valid, resultOut); end
  endtask

  task automatic test_range();
    logic [31:0] addrs [3];
    addrs[0] = 32'd1020; addrs[1] = 32'd1280; addrs[2] = 32'd1026;
    for (int i = 0; i < 3; i++) begin
      nextCycle(); MEM_R_ENIn = 1'b1; ALU_ResIn = addrs[i]; #1;
      checks++; if ({freeze, mem_req} !== 2'b10) begin errors++; $display("FAIL range_idle[%0d]: got freeze,req=%b exp 10", i, {freeze, mem_req}); end
      nextCycle(); #1;
      checks++; if ({freeze, mem_req, err_range, result_valid} !== 4'b0011) begin errors++; $display("FAIL range_done[%0d]: got freeze,req,err,valid=%b exp 0011", i, {freeze, mem_req, err_range, result_valid}); end
      checks++; if (resultOut !== 32'd0) begin errors++; $display("FAIL range_result[%0d]: got %h exp 0", i, resultOut); end
      nextCycle(); MEM_R_ENIn = 1'b0; #1;
      checks++; if ({err_range, mem_req} !== 2'b00) begin errors++; $display("FAIL range_idle_after[%0d]: got err,req=%b exp 00", i, {err_range, mem_req}); end
    end
  endtask

  task automatic test_timeout();
    mem_rdata = 32'hFFFFFFFF;
    nextCycle(); MEM_R_ENIn = 1'b1; ALU_ResIn = 32'd1100; #1;
    checks++; if (freeze !== 1'b1) begin errors++; $display("FAIL timeout_idle: got freeze=%b exp 1", freeze); end
    for (int c = 0; c < 15; c++) begin
      nextCycle(); #1;
      checks++; if ({freeze, mem_req, err_timeout} !== 3'b110 || mem_adr !== 6'd19) begin errors++; $display("FAIL timeout_busy[%0d]: got freeze,req,err=%b adr=%0d exp 110/19", c, {freeze, mem_req, err_timeout}, mem_adr); end
    end
    nextCycle(); #1;
    checks++; if ({freeze, mem_req, err_timeout, result_valid} !== 4'b0011) begin errors++; $display("FAIL timeout_done: got freeze,req,err,valid=%b exp 0011", {freeze, mem_req, err_timeout, result_valid}); end
    checks++; if (resultOut !== 32'd0) begin errors++; $display("FAIL timeout_result: got %h exp 0", resultOut); end
    nextCycle(); MEM_R_ENIn = 1'b0; #1;
    checks++; if ({err_timeout, mem_req, freeze} !== 3'b000) begin errors++; $display("FAIL timeout_idle_after: got err,req,freeze=%b exp 000", {err_timeout, mem_req, freeze}); end
  endtask

  task automatic test_boundary();
    nextCycle(); MEM_R_ENIn = 1'b1; ALU_ResIn = 32'd1276; #1;
    nextCycle(); mem_ack = 1'b1; mem_rdata = 32'hA5A50001; #1;
    checks++; if ({mem_req, mem_adr} !== {1'b1, 6'd63}) begin errors++; $display("FAIL boundary_req: got req=%b adr=%0d exp 1/63", mem_req, mem_adr); end
    nextCycle(); mem_ack = 1'b0; #1;
    checks++; if ({err_range, resultOut} !== {1'b0, 32'hA5A50001}) begin errors++; $display("FAIL boundary_result: got err=%b result=%h exp 0/a5a50001", err_range, resultOut); end
    nextCycle(); MEM_R_ENIn = 1'b0;
  endtask

  task automatic test_rst_mid_access();
    nextCycle(); MEM_R_ENIn = 1'b1; MEM_W_ENIn = 1'b1; ALU_ResIn = 32'd1028; Value_RmIn = 32'h000055AA; #1;
    nextCycle(); #1;
    checks++; if ({mem_req, mem_we, mem_adr} !== {1'b1, 1'b1, 6'd1}) begin errors++; $display("FAIL both_en_write: got req=%b we=%b adr=%0d exp 1/1/1", mem_req, mem_we, mem_adr); end
    nextCycle(); rst = 1'b1; #1;
    checks++; if ({freeze, mem_req} !== 2'b01) begin errors++; $display("FAIL rst_busy2: got freeze,req=%b exp 01", {freeze, mem_req}); end
    nextCycle(); #1;
    checks++; if ({freeze, mem_req, result_valid} !== 3'b000) begin errors++; $display("FAIL rst_after: got freeze,req,valid=%b exp 000", {freeze, mem_req, result_valid}); end
    checks++; if (resultOut !== 32'd0) begin errors++; $display("FAIL rst_result: got %h exp 0", resultOut); end
    rst = 1'b0; #1;
    checks++; if ({freeze, mem_req} !== 2'b10) begin errors++; $display("FAIL rst_state_idle: got freeze,req=%b exp 10", {freeze, mem_req}); end
    MEM_R_ENIn = 1'b0; MEM_W_ENIn = 1'b0;
    nextCycle();
  endtask

  task automatic test_back_to_back();
    nextCycle(); MEM_R_ENIn = 1'b1; ALU_ResIn = 32'd1024; #1;
    nextCycle(); mem_ack = 1'b1; mem_rdata = 32'h11111111; #1;
    checks++; if ({mem_req, mem_adr} !== {1'b1, 6'd0}) begin errors++; $display("FAIL b2b_req1: got req=%b adr=%0d exp 1/0", mem_req, mem_adr); end
    nextCycle(); mem_ack = 1'b0; #1;
    checks++; if ({freeze, mem_req, resultOut} !== {2'b00, 32'h11111111}) begin errors++; $display("FAIL b2b_done1: got freeze,req=%b result=%h exp 00/11111111", {freeze, mem_req}, resultOut); end
    nextCycle(); ALU_ResIn = 32'd1028; #1;
    checks++; if ({freeze, mem_req} !== 2'b10) begin errors++; $display("FAIL b2b_idle2: got freeze,req=%b exp 10", {freeze, mem_req}); end
    nextCycle(); mem_ack = 1'b1; mem_rdata = 32'h22222222; #1;
    checks++; if ({mem_req, mem_adr} !== {1'b1, 6'd1}) begin errors++; $display("FAIL b2b_req2: got req=%b adr=%0d exp 1/1", mem_req, mem_adr); end
    nextCycle(); mem_ack = 1'b0; #1;
    checks++; if ({mem_req, result_valid, resultOut} !== {2'b01, 32'h22222222}) begin errors++; $display("FAIL b2b_done2: got req,valid=%b result=%h exp 01/22222222", {mem_req, result_valid}, resultOut); end
    nextCycle(); MEM_R_ENIn = 1'b0; #1;
    checks++; if ({mem_req, result_valid} !== 2'b00) begin errors++; $display("FAIL b2b_idle_end: got req,valid=%b exp 00", {mem_req, result_valid}); end
  endtask

  initial begin
    rst = 1'b1; MEM_R_ENIn = 1'b0; MEM_W_ENIn = 1'b0;
    ALU_ResIn = '0; Value_RmIn = '0; mem_ack = 1'b0; mem_rdata = '0;
    test_reset();
    test_store();
    test_load();
    test_range();
    test_timeout();
    test_boundary();
    test_rst_mid_access();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
